// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: nibble width, sequencer states, nibble-count helper.
package arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/sub_bla4b.sv
// 4-bit borrow-lookahead subtract slice: {bo, d} = x - y - bi.
// Purely combinational, no internal borrow ripple.
module sub_bla4b (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] br;

  // g: this bit borrows on its own; p: an incoming borrow passes through this bit
  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign br[0] = bi;
  assign br[1] = g[0] | (p[0] & bi);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
  assign bo    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = x ^ y ^ br;

endmodule

// File: rtl/subtractor_seq16b.sv
// Sequential a - b - bin, one nibble per clock, LS nibble first.
// Latency N+1 cycles start->done; start is ignored while busy or in the done cycle.
module subtractor_seq16b
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg
);

  localparam int N  = nibbles(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             brw_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             neg_q;

  logic [NIBBLE_W-1:0] x_nib;
  logic [NIBBLE_W-1:0] y_nib;
  logic [NIBBLE_W-1:0] d_nib;
  logic                bo;
  logic [WIDTH-1:0]    diff_nxt;
  logic                last;

  assign x_nib = a_q[int'(cnt_q)*NIBBLE_W +: NIBBLE_W];
  assign y_nib = b_q[int'(cnt_q)*NIBBLE_W +: NIBBLE_W];
  assign last  = (cnt_q == CW'(N-1));

  sub_bla4b u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .bi (brw_q),
    .d  (d_nib),
    .bo (bo)
  );

  always_comb begin
    diff_nxt = diff_q;
    diff_nxt[int'(cnt_q)*NIBBLE_W +: NIBBLE_W] = d_nib;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          brw_q  <= bin;
          cnt_q  <= '0;
          diff_q <= '0;
          bout_q <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end
        RUN: begin
          diff_q <= diff_nxt;
          brw_q  <= bo;
          if (last) begin
            // flags are set on the final nibble so they are valid in the DONE cycle
            bout_q <= bo;
            zero_q <= (diff_nxt == '0);
            neg_q  <= diff_nxt[WIDTH-1];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule
